// File: rtl/mc_core_ctrl.sv
// mc_core_ctrl - multicycle sequencer for the npc core.
//
// Steps each instruction through fetch request, fetch wait, decode, execute
// and writeback. Owns the PC and the instruction register. Lets exactly one
// register-file write through per instruction. Ebreak, unimplemented
// instructions, fetch timeouts and misaligned jump targets end in terminal
// halt/trap states, which only reset leaves.
//
// Ports:
//   clk, rst            clock (posedge) and asynchronous active-high reset
//   ifu_req_valid/addr  fetch request; addr is always the current PC
//   ifu_req_ready       fetch unit accepts the request
//   ifu_rsp_valid/inst  fetched instruction returned
//   inst                instruction register contents, to the decoder
//   dec_inst_not_ipl    decoder flags an unimplemented instruction
//   dec_is_ebreak       decoder flags ebreak
//   exe_done            execute unit result valid
//   exe_redirect/target next PC comes from exe_target
//   rf_wen              one-cycle register-file write enable
//   current_pc          PC of the instruction in flight
//   halted, trap        sticky terminal status
//   trap_cause, trap_pc 01 illegal, 10 fetch timeout, 11 misaligned target
//   retired             saturating retired-instruction count

module mc_core_ctrl #(
  parameter int             XLEN          = 64,
  parameter int             ILEN          = 32,
  parameter logic [XLEN-1:0] RESET_PC     = 'h8000_0000,
  parameter int             FETCH_TIMEOUT = 255,
  parameter int             TMR_W         = 8,
  parameter int             CNT_W         = 64
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifu_req_valid,
  output logic [XLEN-1:0]  ifu_req_addr,
  input  logic             ifu_req_ready,
  input  logic             ifu_rsp_valid,
  input  logic [ILEN-1:0]  ifu_rsp_inst,
  output logic [ILEN-1:0]  inst,
  input  logic             dec_inst_not_ipl,
  input  logic             dec_is_ebreak,
  input  logic             exe_done,
  input  logic             exe_redirect,
  input  logic [XLEN-1:0]  exe_target,
  output logic             rf_wen,
  output logic [XLEN-1:0]  current_pc,
  output logic             halted,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [XLEN-1:0]  trap_pc,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] FETCH_REQ  = 3'd0;
  localparam logic [2:0] FETCH_WAIT = 3'd1;
  localparam logic [2:0] DECODE     = 3'd2;
  localparam logic [2:0] EXECUTE    = 3'd3;
  localparam logic [2:0] WRITEBACK  = 3'd4;
  localparam logic [2:0] HALT       = 3'd5;
  localparam logic [2:0] TRAP       = 3'd6;

  localparam logic [1:0] CAUSE_ILLEGAL   = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT   = 2'b10;
  localparam logic [1:0] CAUSE_MISALIGN  = 2'b11;

  // The timer counts FETCH_WAIT cycles already spent without a response,
  // so the trap fires in the cycle where it reads FETCH_TIMEOUT-1.
  localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(FETCH_TIMEOUT - 1);

  logic [2:0]       state;
  logic [2:0]       nextState;
  logic [1:0]       nextCause;
  logic [XLEN-1:0]  pc;
  logic [ILEN-1:0]  ir;
  logic [TMR_W-1:0] timer;
  logic [1:0]       causeReg;
  logic [XLEN-1:0]  trapPcReg;
  logic [CNT_W-1:0] retiredCnt;
  logic             badTarget;
  logic             commit;

  // A taken redirect to a non word-aligned target faults in writeback.
  // In that case the instruction does not commit.
  assign badTarget = exe_redirect && (exe_target[1:0] != 2'b00);
  assign commit    = (state == WRITEBACK) && !badTarget;

  assign ifu_req_valid = (state == FETCH_REQ);
  assign ifu_req_addr  = pc;
  assign inst          = ir;
  assign rf_wen        = commit;
  assign current_pc    = pc;
  assign halted        = (state == HALT);
  assign trap          = (state == TRAP);
  assign trap_cause    = causeReg;
  assign trap_pc       = trapPcReg;
  assign retired       = retiredCnt;

  // Next-state selection. HALT and TRAP hold until reset. In FETCH_WAIT a
  // response arriving in the timeout cycle takes priority over the trap.
  always_comb begin
    nextState = state;
    nextCause = 2'b00;
    case (state)
      FETCH_REQ:  if (ifu_req_ready) nextState = FETCH_WAIT;
      FETCH_WAIT: begin
        if (ifu_rsp_valid) begin
          nextState = DECODE;
        end else if (timer == TIMER_LAST) begin
          nextState = TRAP;
          nextCause = CAUSE_TIMEOUT;
        end
      end
      DECODE: begin
        if (dec_inst_not_ipl) begin
          nextState = TRAP;
          nextCause = CAUSE_ILLEGAL;
        end else if (dec_is_ebreak) begin
          nextState = HALT;
        end else begin
          nextState = EXECUTE;
        end
      end
      EXECUTE:   if (exe_done) nextState = WRITEBACK;
      WRITEBACK: begin
        if (badTarget) begin
          nextState = TRAP;
          nextCause = CAUSE_MISALIGN;
        end else begin
          nextState = FETCH_REQ;
        end
      end
      HALT:    nextState = HALT;
      TRAP:    nextState = TRAP;
      default: nextState = FETCH_REQ;
    endcase
  end

  // State register, fetch timer and instruction register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH_REQ;
      timer <= '0;
      ir    <= '0;
    end else begin
      state <= nextState;
      if (state == FETCH_REQ) begin
        timer <= '0;
      end else if (state == FETCH_WAIT && !ifu_rsp_valid) begin
        timer <= timer + TMR_W'(1);
      end
      if (state == FETCH_WAIT && ifu_rsp_valid) begin
        ir <= ifu_rsp_inst;
      end
    end
  end

  // Trap information is captured once, on the transition into TRAP, so it
  // keeps the PC of the faulting instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      causeReg  <= 2'b00;
      trapPcReg <= '0;
    end else if (nextState == TRAP && state != TRAP) begin
      causeReg  <= nextCause;
      trapPcReg <= pc;
    end
  end

  // PC advance and retire count change only on a committing writeback.
  // The PC wraps naturally and the retire counter saturates at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      retiredCnt <= '0;
    end else if (commit) begin
      pc <= exe_redirect ? exe_target : pc + XLEN'(4);
      if (retiredCnt != '1) begin
        retiredCnt <= retiredCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mc_core_ctrl.sv
// tb_mc_core_ctrl - self-checking bench for mc_core_ctrl.
//
// A behavioural model follows each instruction through its lifecycle phases
// and is compared with the DUT on every falling clock edge. Directed
// scenarios add literal expectations, and randomized episodes exercise
// arbitrary handshake timing.

module tb_mc_core_ctrl;

  localparam logic [63:0] RESET_PC      = 64'h8000_0000;
  localparam int          FETCH_TIMEOUT = 255;

  logic        clk;
  logic        rst;
  logic        ready;
  logic        rspValid;
  logic [31:0] rspInst;
  logic        notIpl;
  logic        isEbreak;
  logic        exeDone;
  logic        redirect;
  logic [63:0] target;

  logic        reqValid;
  logic [63:0] reqAddr;
  logic [31:0] inst;
  logic        rfWen;
  logic [63:0] curPc;
  logic        halted;
  logic        trap;
  logic [1:0]  trapCause;
  logic [63:0] trapPc;
  logic [63:0] retired;

  int   errors = 0;
  int   checks = 0;
  logic sawWen;
  bit   compareOn = 0;

  // Model state: the lifecycle phase of the instruction, how many cycles
  // the fetch has waited so far, and the architectural results.
  string       mPhase;
  int          mWaited;
  logic [63:0] mPc;
  logic [63:0] mRetired;
  logic [63:0] mTrapPc;
  logic [31:0] mIr;
  logic [1:0]  mCause;
  bit          mHalted;
  bit          mTrap;

  mc_core_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .ifu_req_valid    (reqValid),
    .ifu_req_addr     (reqAddr),
    .ifu_req_ready    (ready),
    .ifu_rsp_valid    (rspValid),
    .ifu_rsp_inst     (rspInst),
    .inst             (inst),
    .dec_inst_not_ipl (notIpl),
    .dec_is_ebreak    (isEbreak),
    .exe_done         (exeDone),
    .exe_redirect     (redirect),
    .exe_target       (target),
    .rf_wen           (rfWen),
    .current_pc       (curPc),
    .halted           (halted),
    .trap             (trap),
    .trap_cause       (trapCause),
    .trap_pc          (trapPc),
    .retired          (retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic modelTrap(input logic [1:0] cause);
    mTrap   = 1'b1;
    mCause  = cause;
    mTrapPc = mPc;
    mPhase  = "trapped";
  endtask

  // Reference model: advances one clock at a time using the inputs that
  // were stable across the edge, and resets immediately on rst.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mPhase   = "fetchReq";
      mWaited  = 0;
      mPc      = RESET_PC;
      mIr      = '0;
      mRetired = '0;
      mTrapPc  = '0;
      mCause   = 2'b00;
      mHalted  = 1'b0;
      mTrap    = 1'b0;
    end else if (mPhase == "fetchReq") begin
      if (ready) begin
        mPhase  = "fetchWait";
        mWaited = 0;
      end
    end else if (mPhase == "fetchWait") begin
      if (rspValid) begin
        mIr    = rspInst;
        mPhase = "decode";
      end else begin
        mWaited++;
        if (mWaited >= FETCH_TIMEOUT) modelTrap(2'b10);
      end
    end else if (mPhase == "decode") begin
      if (notIpl) modelTrap(2'b01);
      else if (isEbreak) begin
        mHalted = 1'b1;
        mPhase  = "halted";
      end else mPhase = "execute";
    end else if (mPhase == "execute") begin
      if (exeDone) mPhase = "writeback";
    end else if (mPhase == "writeback") begin
      if (redirect && (target % 4 != 0)) modelTrap(2'b11);
      else begin
        if (mRetired != 64'hFFFF_FFFF_FFFF_FFFF) mRetired = mRetired + 1;
        mPc    = redirect ? target : mPc + 64'd4;
        mPhase = "fetchReq";
      end
    end
  end

  // Compare every output with the model in the middle of each cycle.
  always @(negedge clk) begin
    if (compareOn && !rst) begin
      checkOutput("reqValid", {63'd0, reqValid}, {63'd0, mPhase == "fetchReq"});
      checkOutput("reqAddr", reqAddr, mPc);
      checkOutput("inst", {32'd0, inst}, {32'd0, mIr});
      checkOutput("rfWen", {63'd0, rfWen},
                  {63'd0, (mPhase == "writeback") && !(redirect && (target % 4 != 0))});
      checkOutput("currentPc", curPc, mPc);
      checkOutput("halted", {63'd0, halted}, {63'd0, mHalted});
      checkOutput("trap", {63'd0, trap}, {63'd0, mTrap});
      checkOutput("trapCause", {62'd0, trapCause}, {62'd0, mCause});
      checkOutput("trapPc", trapPc, mTrapPc);
      checkOutput("retired", retired, mRetired);
    end
  end

  // Drive one cycle of inputs, sample rf_wen mid-cycle, then step past
  // the next rising edge.
  task automatic applyStimulus(input logic rdy, input logic rv, input logic [31:0] ri,
                               input logic ni, input logic eb, input logic dn,
                               input logic rd, input logic [63:0] tg);
    ready    = rdy;
    rspValid = rv;
    rspInst  = ri;
    notIpl   = ni;
    isEbreak = eb;
    exeDone  = dn;
    redirect = rd;
    target   = tg;
    #2;
    sawWen = rfWen;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    ready = 1'b0; rspValid = 1'b0; rspInst = '0; notIpl = 1'b0;
    isEbreak = 1'b0; exeDone = 1'b0; redirect = 1'b0; target = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Leaves the controller in DECODE holding instruction i.
  task automatic fetchInst(input logic [31:0] i);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    applyStimulus(1'b0, 1'b1, i, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
  endtask

  task automatic runInst(input logic rd, input logic [63:0] tg, output logic wen);
    fetchInst(32'h0000_0013);
    idle();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, rd, tg);
    wen = sawWen;
  endtask

  initial begin
    int   n;
    int   wenCount;
    int   wenAt;
    logic w;
    logic [63:0] tg;

    rst = 1'b0;
    #1;
    doReset();
    compareOn = 1;

    // Reset state and one minimum-latency instruction.
    checkOutput("resetAddr", reqAddr, 64'h8000_0000);
    checkOutput("resetValid", {63'd0, reqValid}, 64'd1);
    checkOutput("resetRetired", retired, 64'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0);
    wenCount = 0;
    wenAt = 0;
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0);
      if (sawWen) begin
        wenCount++;
        wenAt = i;
      end
      if (i == 1) checkOutput("irLoaded", {32'd0, inst}, 64'h13);
    end
    idle();
    if (sawWen) wenCount++;
    checkOutput("wenCount", 64'(wenCount), 64'd1);
    checkOutput("wenLatency", 64'(wenAt), 64'd4);
    checkOutput("pcAfterOne", curPc, 64'h8000_0004);
    checkOutput("retiredOne", retired, 64'd1);
    checkOutput("nextReqAddr", reqAddr, 64'h8000_0004);
    checkOutput("modelPcOne", mPc, 64'h8000_0004);

    // Back-pressure: request held, responses in FETCH_REQ ignored.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, (i % 2) == 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
      checkOutput("holdValid", {63'd0, reqValid}, 64'd1);
      checkOutput("holdAddr", reqAddr, 64'h8000_0004);
      checkOutput("holdIr", {32'd0, inst}, 64'h13);
    end

    // Fetch timeout.
    doReset();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    n = 0;
    while (!trap && n < 400) begin
      idle();
      n++;
    end
    checkOutput("timeoutCycles", 64'(n), 64'd255);
    checkOutput("timeoutCause", {62'd0, trapCause}, 64'd2);
    checkOutput("timeoutPc", trapPc, 64'h8000_0000);
    idle();
    idle();
    checkOutput("timeoutNoReq", {63'd0, reqValid}, 64'd0);

    // Illegal has priority over ebreak.
    doReset();
    fetchInst(32'h0010_0073);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0);
    checkOutput("illegalTrap", {63'd0, trap}, 64'd1);
    checkOutput("illegalCause", {62'd0, trapCause}, 64'd1);
    checkOutput("illegalNotHalted", {63'd0, halted}, 64'd0);

    // Ebreak alone halts with nothing retired or written.
    doReset();
    fetchInst(32'h0010_0073);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
    checkOutput("ebreakHalted", {63'd0, halted}, 64'd1);
    checkOutput("ebreakNoTrap", {63'd0, trap}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0);
      checkOutput("haltNoWen", {63'd0, sawWen}, 64'd0);
    end
    checkOutput("haltRetired", retired, 64'd0);
    checkOutput("haltPc", curPc, 64'h8000_0000);

    // Misaligned redirect target.
    doReset();
    runInst(1'b1, 64'h8000_0102, w);
    checkOutput("misalignNoWen", {63'd0, w}, 64'd0);
    checkOutput("misalignCause", {62'd0, trapCause}, 64'd3);
    checkOutput("misalignTrapPc", trapPc, 64'h8000_0000);
    checkOutput("misalignRetired", retired, 64'd0);

    // Aligned redirect, then PC wrap at the top of the address space.
    doReset();
    runInst(1'b1, 64'h8000_0100, w);
    checkOutput("redirWen", {63'd0, w}, 64'd1);
    checkOutput("redirPc", curPc, 64'h8000_0100);
    runInst(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, w);
    checkOutput("topPc", curPc, 64'hFFFF_FFFF_FFFF_FFFC);
    runInst(1'b0, 64'd0, w);
    checkOutput("wrapPc", curPc, 64'd0);
    checkOutput("wrapRetired", retired, 64'd3);
    checkOutput("modelRetired", mRetired, 64'd3);

    // Asynchronous reset in the middle of EXECUTE.
    doReset();
    runInst(1'b0, 64'd0, w);
    fetchInst(32'h0000_0013);
    idle();
    rst = 1'b1;
    #1;
    checkOutput("asyncPc", curPc, 64'h8000_0000);
    checkOutput("asyncRetired", retired, 64'd0);
    checkOutput("asyncIr", {32'd0, inst}, 64'd0);
    checkOutput("asyncValid", {63'd0, reqValid}, 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("asyncNextAddr", reqAddr, 64'h8000_0000);

    // Randomized episodes checked by the model on every cycle.
    for (int e = 0; e < 8; e++) begin
      doReset();
      for (int c = 0; c < 300; c++) begin
        tg = {$urandom, $urandom};
        if ($urandom_range(0, 3) != 0) tg[1:0] = 2'b00;
        applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                      $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                      $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), tg);
      end
    end

    compareOn = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_core_ctrl.md
Name: mc_core_ctrl

Overview:
Multicycle sequencer for the npc core. It replaces the single-cycle fetch/execute/writeback coupling with an explicit state machine. The block owns the PC register and the instruction register (IR), and drives a valid/ready fetch handshake. It gates register-file writes to one cycle per instruction and turns ebreak, unimplemented instructions, fetch timeouts and misaligned jump targets into sticky halt/trap states. The decoder, ALU and RegisterFile sit alongside it; this block provides their sequencing only.

Parameters:
XLEN, 64, width of PC and address datapath
ILEN, 32, instruction width
RESET_PC, 64'h8000_0000, PC value loaded on reset
FETCH_TIMEOUT, 255, maximum FETCH_WAIT cycles before a fetch trap (1..2^TMR_W-1)
TMR_W, 8, fetch timer width
CNT_W, 64, retired-instruction counter width

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  asynchronous, active-high reset
ifu_req_valid  out  1  fetch request valid
ifu_req_addr  out  XLEN  fetch address (= current_pc)
ifu_req_ready  in  1  fetch unit accepts request
ifu_rsp_valid  in  1  fetched instruction valid
ifu_rsp_inst  in  ILEN  fetched instruction
inst  out  ILEN  IR contents, fed to decoder
dec_inst_not_ipl  in  1  decoder: instruction not implemented
dec_is_ebreak  in  1  decoder: ebreak
exe_done  in  1  ALU/EXU result valid this cycle
exe_redirect  in  1  next PC comes from exe_target
exe_target  in  XLEN  jump/branch target
rf_wen  out  1  register-file write enable, one-cycle pulse
current_pc  out  XLEN  PC of the instruction in flight
halted  out  1  sticky, ebreak reached
trap  out  1  sticky, fault reached
trap_cause  out  2  01 illegal, 10 fetch timeout, 11 misaligned target
trap_pc  out  XLEN  PC of the faulting instruction
retired  out  CNT_W  count of retired instructions

Behaviour:
- Reset (async, any state, including mid-fetch or mid-execute):
  - state=FETCH_REQ, current_pc=RESET_PC, inst=0.
  - halted=0, trap=0, trap_cause=0, trap_pc=0, retired=0, timer=0.
  - Deassertion takes effect on the next clk edge.
- States: FETCH_REQ, FETCH_WAIT, DECODE, EXECUTE, WRITEBACK, HALT, TRAP.
- FETCH_REQ:
  - ifu_req_valid=1 and ifu_req_addr=current_pc, held until ifu_req_ready.
  - On ready: go to FETCH_WAIT, timer cleared.
  - ifu_rsp_valid is ignored in this state.
- FETCH_WAIT:
  - On ifu_rsp_valid: IR<=ifu_rsp_inst, go to DECODE.
  - Otherwise timer increments. If timer==FETCH_TIMEOUT-1 with no response: go to TRAP with cause 10.
  - If the response and the timeout coincide, the response wins.
- DECODE: exactly one cycle; IR is stable during it. Priority, highest first:
  - dec_inst_not_ipl: go to TRAP, cause 01.
  - dec_is_ebreak: go to HALT.
  - otherwise: go to EXECUTE.
- EXECUTE: wait for exe_done (zero or more cycles); on exe_done go to WRITEBACK.
- WRITEBACK: one cycle.
  - If exe_redirect and exe_target[1:0]!=0: go to TRAP, cause 11. rf_wen=0, PC unchanged, retired unchanged.
  - Otherwise: rf_wen=1 for this cycle only, retired+=1 (saturates at all-ones), then go to FETCH_REQ.
  - New PC: exe_target when exe_redirect, else current_pc+4 (mod 2^XLEN, wraps).
- HALT: halted=1. Terminal until reset; no requests, rf_wen=0, PC frozen.
- TRAP:
  - trap=1; trap_pc=current_pc and trap_cause are latched on entry.
  - Terminal until reset; no requests, rf_wen=0.
- ifu_req_valid=0 in every state except FETCH_REQ.
- rf_wen=0 in every state except WRITEBACK.
- Minimum latency: 5 cycles per instruction (ready and rsp_valid asserted immediately, exe_done asserted immediately).

Test Plan:
- Reset release; ifu_req_ready=1, rsp inst=32'h00000013 on the next cycle, exe_done=1, redirect=0 -> ifu_req_addr=80000000. rf_wen pulses exactly once, 4 cycles after the request is accepted. PC=80000004, retired=1, then the next request goes out at 80000004.
- Hold ifu_req_ready=0 for 3 cycles -> ifu_req_valid stays high with a stable address. rsp_valid pulses during FETCH_REQ are ignored and IR stays unchanged.
- Accept the request, never send rsp_valid, FETCH_TIMEOUT=255 -> trap=1 after 255 FETCH_WAIT cycles. trap_cause=10, trap_pc=80000000, no further requests.
- DECODE with dec_inst_not_ipl=1 and dec_is_ebreak=1 -> TRAP cause 01, halted=0. A separate run with ebreak only -> halted=1, retired unchanged, rf_wen never asserts.
- WRITEBACK with redirect=1: target=80000102 -> TRAP cause 11, no rf_wen. Target=80000100 -> PC=80000100. Also current_pc=all-ones-minus-3 with no redirect -> PC wraps to 0.
- Assert rst during EXECUTE while exe_done=0 -> outputs reset immediately without waiting for clk. The next fetch is at RESET_PC and retired=0.
